// File: rtl/bp_cfg_sequencer_pkg.sv
// Shared constants for the post-reset config sequencer: register map, write order and FSM states.
// The RD/ERROR states exist only when BP_CFG_SEQ_READBACK_EN is defined.
package bp_cfg_sequencer_pkg;

   localparam int cfg_reg_addr_width_lp = 16;

   localparam logic [15:0] cfg_addr_freeze_c      = 16'h0200;
   localparam logic [15:0] cfg_addr_core_id_c     = 16'h0201;
   localparam logic [15:0] cfg_addr_lce_id0_c     = 16'h0202;
   localparam logic [15:0] cfg_addr_lce_id1_c     = 16'h0203;
   localparam logic [15:0] cfg_addr_cce_id_c      = 16'h0204;
   localparam logic [15:0] cfg_addr_icache_mode_c = 16'h0205;
   localparam logic [15:0] cfg_addr_dcache_mode_c = 16'h0206;
   localparam logic [15:0] cfg_addr_cce_mode_c    = 16'h0207;

   // Per-core write order, indexed by reg_cnt.
   localparam logic [15:0] cfg_reg_order_c [8] = '{
      cfg_addr_freeze_c,
      cfg_addr_core_id_c,
      cfg_addr_lce_id0_c,
      cfg_addr_lce_id1_c,
      cfg_addr_cce_id_c,
      cfg_addr_icache_mode_c,
      cfg_addr_dcache_mode_c,
      cfg_addr_cce_mode_c
   };

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CFG      = 3'd1,
      S_UNFREEZE = 3'd2,
      S_DONE     = 3'd3
`ifdef BP_CFG_SEQ_READBACK_EN
      ,
      S_RD       = 3'd4,
      S_ERROR    = 3'd5
`endif
   } seq_state_e;

endpackage

// File: rtl/bp_cfg_seq_datagen.sv
// Combinational map from sequencer position (reg_cnt, core_cnt, phase) and mode inputs
// to the config register address and zero-extended write data.
module bp_cfg_seq_datagen
   import bp_cfg_sequencer_pkg::*;
#(
   parameter int core_width_p = 2,
   parameter int addr_width_p = 16,
   parameter int data_width_p = 32
)(
   input  logic [2:0]              reg_idx_i,
   input  logic [core_width_p-1:0] core_idx_i,
   input  logic                    unfreeze_i,
   input  logic [1:0]              icache_mode_i,
   input  logic [1:0]              dcache_mode_i,
   input  logic [1:0]              cce_mode_i,
   output logic [addr_width_p-1:0] addr_o,
   output logic [data_width_p-1:0] data_o
);

   always_comb begin
      addr_o = addr_width_p'(cfg_reg_order_c[reg_idx_i]);
      data_o = '0;
      if (unfreeze_i) begin
         addr_o = addr_width_p'(cfg_addr_freeze_c);
      end else begin
         case (reg_idx_i)
            3'd0:    data_o = data_width_p'(1'b1);
            3'd1:    data_o = data_width_p'(core_idx_i);
            3'd2:    data_o = data_width_p'({core_idx_i, 1'b0});
            3'd3:    data_o = data_width_p'({core_idx_i, 1'b1});
            3'd4:    data_o = data_width_p'(core_idx_i);
            3'd5:    data_o = data_width_p'(icache_mode_i);
            3'd6:    data_o = data_width_p'(dcache_mode_i);
            default: data_o = data_width_p'(cce_mode_i);
         endcase
      end
   end

endmodule

// File: rtl/bp_cfg_sequencer.sv
// Post-reset config sequencer: freezes and programs each core, then releases them in order.
// Define BP_CFG_SEQ_READBACK_EN to read back and verify every write.
module bp_cfg_sequencer
   import bp_cfg_sequencer_pkg::*;
#(
   parameter int num_core_p       = 4,
   parameter int cfg_addr_width_p = 16,
   parameter int cfg_data_width_p = 32,
   parameter int auto_start_p     = 1,
   localparam int dest_width_lp   = (num_core_p > 1) ? $clog2(num_core_p) : 1
)(
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        start_i,
   input  logic [1:0]                  icache_mode_i,
   input  logic [1:0]                  dcache_mode_i,
   input  logic [1:0]                  cce_mode_i,
   output logic                        cfg_v_o,
   input  logic                        cfg_ready_i,
   output logic                        cfg_w_o,
   output logic [dest_width_lp-1:0]    cfg_dest_o,
   output logic [cfg_addr_width_p-1:0] cfg_addr_o,
   output logic [cfg_data_width_p-1:0] cfg_data_o,
   input  logic                        cfg_rdata_v_i,
   input  logic [cfg_data_width_p-1:0] cfg_rdata_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        error_o
);

   seq_state_e                  state_q, state_d;
   logic [2:0]                  reg_cnt_q, reg_cnt_d;
   logic [dest_width_lp-1:0]    core_cnt_q, core_cnt_d;
   logic                        unfreeze_q, unfreeze_d;
   logic                        cfg_v_q, cfg_v_d;
   logic [dest_width_lp-1:0]    cfg_dest_q, cfg_dest_d;
   logic [cfg_addr_width_p-1:0] cfg_addr_q, cfg_addr_d;
   logic [cfg_data_width_p-1:0] cfg_data_q, cfg_data_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
`ifdef BP_CFG_SEQ_READBACK_EN
   logic                        cfg_w_q, cfg_w_d;
   logic                        rd_wait_q, rd_wait_d;
   logic                        error_q, error_d;
`endif

   logic                        accept;
   logic                        start_seq;
   logic                        wr_step;
   logic                        last_core;
   logic                        load_payload;
   logic [cfg_addr_width_p-1:0] gen_addr;
   logic [cfg_data_width_p-1:0] gen_data;

   assign accept    = cfg_v_q & cfg_ready_i;
   assign last_core = (core_cnt_q == dest_width_lp'(num_core_p - 1));
   assign start_seq = ((state_q == S_IDLE) && ((auto_start_p != 0) || start_i))
                   || ((state_q == S_DONE) && start_i);

`ifdef BP_CFG_SEQ_READBACK_EN
   // A write only counts as complete once its readback has matched.
   assign wr_step = (state_q == S_RD) && rd_wait_q && cfg_rdata_v_i
                 && (cfg_rdata_i == cfg_data_q);
`else
   assign wr_step = accept && ((state_q == S_CFG) || (state_q == S_UNFREEZE));
`endif

   always_comb begin
      state_d      = state_q;
      reg_cnt_d    = reg_cnt_q;
      core_cnt_d   = core_cnt_q;
      unfreeze_d   = unfreeze_q;
      cfg_v_d      = cfg_v_q;
      busy_d       = busy_q;
      done_d       = done_q;
      load_payload = 1'b0;
`ifdef BP_CFG_SEQ_READBACK_EN
      cfg_w_d      = cfg_w_q;
      rd_wait_d    = rd_wait_q;
      error_d      = error_q;
`endif
      if (start_seq) begin
         state_d      = S_CFG;
         reg_cnt_d    = '0;
         core_cnt_d   = '0;
         unfreeze_d   = 1'b0;
         cfg_v_d      = 1'b1;
         busy_d       = 1'b1;
         done_d       = 1'b0;
         load_payload = 1'b1;
`ifdef BP_CFG_SEQ_READBACK_EN
         cfg_w_d      = 1'b1;
`endif
      end else if (wr_step) begin
`ifdef BP_CFG_SEQ_READBACK_EN
         cfg_w_d = 1'b1;
`endif
         if (unfreeze_q && last_core) begin
            state_d = S_DONE;
            cfg_v_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end else begin
            cfg_v_d      = 1'b1;
            load_payload = 1'b1;
            state_d      = S_CFG;
            if (unfreeze_q) begin
               core_cnt_d = core_cnt_q + dest_width_lp'(1);
               state_d    = S_UNFREEZE;
            end else begin
               reg_cnt_d = reg_cnt_q + 3'd1;
               if (reg_cnt_q == 3'd7) begin
                  if (last_core) begin
                     core_cnt_d = '0;
                     unfreeze_d = 1'b1;
                     state_d    = S_UNFREEZE;
                  end else begin
                     core_cnt_d = core_cnt_q + dest_width_lp'(1);
                  end
               end
            end
         end
      end
`ifdef BP_CFG_SEQ_READBACK_EN
      else if (accept && ((state_q == S_CFG) || (state_q == S_UNFREEZE))) begin
         // Reissue the same dest/addr as a read; payload registers hold the expected data.
         state_d   = S_RD;
         cfg_w_d   = 1'b0;
         rd_wait_d = 1'b0;
      end else if ((state_q == S_RD) && !rd_wait_q && accept) begin
         cfg_v_d   = 1'b0;
         rd_wait_d = 1'b1;
      end else if ((state_q == S_RD) && rd_wait_q && cfg_rdata_v_i) begin
         state_d = S_ERROR;
         error_d = 1'b1;
         cfg_v_d = 1'b0;
         busy_d  = 1'b0;
      end
`endif
   end

   bp_cfg_seq_datagen #(
      .core_width_p (dest_width_lp),
      .addr_width_p (cfg_addr_width_p),
      .data_width_p (cfg_data_width_p)
   ) u_datagen (
      .reg_idx_i     (reg_cnt_d),
      .core_idx_i    (core_cnt_d),
      .unfreeze_i    (unfreeze_d),
      .icache_mode_i (icache_mode_i),
      .dcache_mode_i (dcache_mode_i),
      .cce_mode_i    (cce_mode_i),
      .addr_o        (gen_addr),
      .data_o        (gen_data)
   );

   // Payload only moves when a new request is launched, keeping it stable under backpressure.
   always_comb begin
      cfg_dest_d = cfg_dest_q;
      cfg_addr_d = cfg_addr_q;
      cfg_data_d = cfg_data_q;
      if (load_payload) begin
         cfg_dest_d = core_cnt_d;
         cfg_addr_d = gen_addr;
         cfg_data_d = gen_data;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         reg_cnt_q  <= '0;
         core_cnt_q <= '0;
         unfreeze_q <= 1'b0;
         cfg_v_q    <= 1'b0;
         cfg_dest_q <= '0;
         cfg_addr_q <= '0;
         cfg_data_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef BP_CFG_SEQ_READBACK_EN
         cfg_w_q    <= 1'b1;
         rd_wait_q  <= 1'b0;
         error_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         reg_cnt_q  <= reg_cnt_d;
         core_cnt_q <= core_cnt_d;
         unfreeze_q <= unfreeze_d;
         cfg_v_q    <= cfg_v_d;
         cfg_dest_q <= cfg_dest_d;
         cfg_addr_q <= cfg_addr_d;
         cfg_data_q <= cfg_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef BP_CFG_SEQ_READBACK_EN
         cfg_w_q    <= cfg_w_d;
         rd_wait_q  <= rd_wait_d;
         error_q    <= error_d;
`endif
      end
   end

   assign cfg_v_o    = cfg_v_q;
   assign cfg_dest_o = cfg_dest_q;
   assign cfg_addr_o = cfg_addr_q;
   assign cfg_data_o = cfg_data_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
`ifdef BP_CFG_SEQ_READBACK_EN
   assign cfg_w_o    = cfg_w_q;
   assign error_o    = error_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^{cfg_rdata_v_i, cfg_rdata_i};
   assign cfg_w_o      = 1'b1;
   assign error_o      = 1'b0;
`endif

endmodule
